// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe
//   Fully pipelined barrel shifter. Each of the log2(WIDTH) shift levels is a
//   registered stage, so stage k applies a shift of 2^k when bit k of the shift
//   amount is set. A valid/ready handshake flows through the stages, so
//   downstream back-pressure stalls the pipe without losing or reordering
//   operations.
//
// Parameters
//   WIDTH      data width, power of two, 4..64
//   SW         shift-amount width, derived as $clog2(WIDTH)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous clear of every in-flight operation
//   in_valid   operation offered
//   in_ready   operation accepted on this edge when high together with in_valid
//   in_data    operand
//   in_shamt   shift amount, 0..WIDTH-1
//   in_op      00 SLL, 01 SRL, 10 SRA, 11 ROL
//   out_valid  result present
//   out_ready  consumer accepts result
//   out_data   shifted result
//   out_op     op of the result, passed through for writeback decode

module barrel_shift_pipe #(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_op
);

  localparam int unsigned S = SW;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_e;

  // One shift level: shift by 2^lvl when bit lvl of the shift amount is set.
  // SRA replicates bit WIDTH-1 of the value entering the level; since every
  // earlier level preserved it, that is still the original sign bit.
  function automatic logic [WIDTH-1:0] shift_level(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input logic [SW-1:0]    shamt,
    input int unsigned      lvl
  );
    logic [WIDTH-1:0] r;
    int unsigned      amt;
    amt = 32'd1 << lvl;
    r   = d;
    if (shamt[lvl]) begin
      case (op_e'(op))
        OP_SLL:  r = d << amt;
        OP_SRL:  r = d >> amt;
        OP_SRA:  r = $signed(d) >>> amt;
        OP_ROL:  r = (d << amt) | (d >> (WIDTH - amt));
        default: r = d;
      endcase
    end
    return r;
  endfunction

  // Per-stage registers
  logic [S-1:0]     valid_q;
  logic [WIDTH-1:0] data_q  [S];
  logic [SW-1:0]    shamt_q [S];
  logic [1:0]       op_q    [S];

  // ready[k] is the stage-k load enable; ready[S] is the consumer.
  // The chain is combinational so a full pipe with out_ready high has no bubble.
  logic [S:0] ready;

  assign ready[S] = out_ready;

  for (genvar k = 0; k < S; k++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    logic [SW-1:0]    up_shamt;
    logic [1:0]       up_op;
    logic [WIDTH-1:0] nxt_data;

    if (k == 0) begin : g_first
      always_comb begin
        up_valid = in_valid;
        up_data  = in_data;
        up_shamt = in_shamt;
        up_op    = in_op;
      end
    end else begin : g_next
      always_comb begin
        up_valid = valid_q[k-1];
        up_data  = data_q[k-1];
        up_shamt = shamt_q[k-1];
        up_op    = op_q[k-1];
      end
    end

    always_comb begin
      nxt_data = shift_level(up_data, up_op, up_shamt, k);
    end

    assign ready[k] = !valid_q[k] || ready[k+1];

    // flush only clears valid; payload registers keep loading normally since
    // they are never observed while the matching valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        op_q[k]    <= '0;
      end else begin
        if (flush) begin
          valid_q[k] <= 1'b0;
        end else if (ready[k]) begin
          valid_q[k] <= up_valid;
        end
        if (ready[k] && up_valid) begin
          data_q[k]  <= nxt_data;
          shamt_q[k] <= up_shamt;
          op_q[k]    <= up_op;
        end
      end
    end
  end

  assign in_ready  = ready[0];
  assign out_valid = valid_q[S-1];
  assign out_data  = data_q[S-1];
  assign out_op    = op_q[S-1];

endmodule

// File: tb/tb_barrel_shift_pipe.sv
module tb_barrel_shift_pipe;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned SW    = 5;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SW-1:0]    in_shamt;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_op;

  barrel_shift_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_op    (out_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [1:0]  op;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [31:0] d;
    logic [4:0]  sh;
    logic [1:0]  op;
    logic [31:0] e;
  } vec_t;

  vec_t vecs [14];
  vec_t bp   [8];

  // Result monitor: a handshake seen at the negedge completes on the next posedge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e.data);
        check("out_op", {30'b0, out_op}, {30'b0, e.op});
      end
    end
  end

  task automatic issue(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] op,
                       input logic [31:0] exp, input bit push);
    int unsigned waited = 0;
    exp_t e;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = sh;
    in_op    = op;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("issue_timeout", {31'b0, in_ready}, 32'd1);
    end else if (push) begin
      e.data = exp;
      e.op   = op;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Issue one op and count negedges after the accepting edge until out_valid.
  task automatic issue_timed(input string tag, input logic [31:0] d, input logic [4:0] sh,
                             input logic [1:0] op, input logic [31:0] exp);
    int unsigned lat = 0;
    issue(d, sh, op, exp, 1'b1);
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check(tag, lat, 32'd5);
  endtask

  task automatic drain(input string tag);
    int unsigned waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0) check(tag, exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs = '{
      '{32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000},
      '{32'h8000_0000, 5'd4,  2'b01, 32'h0800_0000},
      '{32'h7FFF_FFF0, 5'd4,  2'b10, 32'h07FF_FFFF},
      '{32'h8000_0001, 5'd1,  2'b11, 32'h0000_0003},
      '{32'h1234_5678, 5'd0,  2'b11, 32'h1234_5678},
      '{32'hDEAD_BEEF, 5'd8,  2'b00, 32'hADBE_EF00},
      '{32'hDEAD_BEEF, 5'd16, 2'b01, 32'h0000_DEAD},
      '{32'hDEAD_BEEF, 5'd4,  2'b11, 32'hEADB_EEFD},
      '{32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF},
      '{32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001},
      '{32'h8000_0000, 5'd31, 2'b11, 32'h4000_0000},
      '{32'hFFFF_FFFF, 5'd0,  2'b00, 32'hFFFF_FFFF},
      '{32'h1234_5678, 5'd0,  2'b10, 32'h1234_5678},
      '{32'h4000_0000, 5'd30, 2'b10, 32'h0000_0001}
    };
    bp = '{
      '{32'h0000_0003, 5'd2,  2'b00, 32'h0000_000C},
      '{32'hF000_0000, 5'd28, 2'b01, 32'h0000_000F},
      '{32'h8000_0000, 5'd1,  2'b10, 32'hC000_0000},
      '{32'h0000_000F, 5'd30, 2'b11, 32'hC000_0003},
      '{32'h1234_5678, 5'd4,  2'b00, 32'h2345_6780},
      '{32'h1234_5678, 5'd4,  2'b01, 32'h0123_4567},
      '{32'h8765_4321, 5'd8,  2'b10, 32'hFF87_6543},
      '{32'h8765_4321, 5'd8,  2'b11, 32'h6543_2187}
    };

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = '0;
    out_ready = 1'b1;

    // Reset state, before any clock edge
    #2;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_op", {30'b0, out_op}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency with SLL 1 by 31
    issue_timed("latency_sll", 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000);
    drain("drain_latency");

    // Directed vectors, back to back
    @(posedge clk);
    #1;
    for (int i = 0; i < 14; i++) issue(vecs[i].d, vecs[i].sh, vecs[i].op, vecs[i].e, 1'b1);
    drain("drain_vectors");

    // Back-pressure: out_ready low from just after edge 3 to just after edge 10
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 8; i++) issue(bp[i].d, bp[i].sh, bp[i].op, bp[i].e, 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_in_ready_filling", {31'b0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check("bp_in_ready_full", {31'b0, in_ready}, 32'd0);
          check("bp_out_valid_held", {31'b0, out_valid}, 32'd1);
          check("bp_out_data_held", out_data, 32'h0000_000C);
          check("bp_out_op_held", {30'b0, out_op}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("drain_bp");

    // Flush with 3 ops in flight plus a simultaneous input
    @(posedge clk);
    #1;
    issue(32'h0000_0001, 5'd1, 2'b00, 32'h0, 1'b0);
    issue(32'h0000_0002, 5'd1, 2'b00, 32'h0, 1'b0);
    issue(32'h0000_0003, 5'd1, 2'b00, 32'h0, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'hAAAA_5555;
    in_shamt = 5'd3;
    in_op    = 2'b01;
    flush    = 1'b1;
    @(negedge clk);
    check("flush_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    issue(32'h0000_F000, 5'd16, 2'b11, 32'hF000_0000, 1'b1);
    drain("drain_flush");

    // Asynchronous reset with a full, stalled pipeline
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) issue(bp[i].d, bp[i].sh, bp[i].op, bp[i].e, 1'b0);
    @(negedge clk);
    check("pre_rst_out_valid", {31'b0, out_valid}, 32'd1);
    check("pre_rst_out_data", out_data, 32'h0000_000C);
    check("pre_rst_in_ready", {31'b0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_out_data", out_data, 32'd0);
    check("async_rst_out_op", {30'b0, out_op}, 32'd0);
    check("async_rst_in_ready", {31'b0, in_ready}, 32'd1);
    #20;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    issue_timed("latency_after_rst", 32'h8000_0001, 5'd1, 2'b10, 32'hC000_0000);
    drain("drain_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
